// File: rtl/lzw_seq_ctrl.sv
// Top-level sequencer for the LZW compressor: power-up delay, code RAM init,
// receive wait, LZW launch and transmit drain, with a per-state watchdog.
module lzw_seq_ctrl #(
    parameter int unsigned PWR_UP_CYCLES  = 66,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 21
) (
    input  logic       CLK66,
    input  logic       RST_N,
    input  logic       SER_RECV_DONE,
    input  logic       DONE_CR,
    input  logic       LZW_DONE,
    input  logic       TX_BUSY,
    input  logic       TX_FIFO_EMPTY,
    input  logic       RESTART,
    output logic       PWR_UP,
    output logic       INIT_CR,
    output logic       INIT_LZW,
    output logic       FINAL_DONE,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
    output logic [3:0] STATE_DBG
);

    typedef enum logic [3:0] {
        S_PWRUP     = 4'd0,
        S_INIT_CR   = 4'd1,
        S_WAIT_CR   = 4'd2,
        S_WAIT_RX   = 4'd3,
        S_START_LZW = 4'd4,
        S_WAIT_LZW  = 4'd5,
        S_DRAIN_TX  = 4'd6,
        S_DONE      = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CR   = 2'd1;
    localparam logic [1:0] ERR_LZW  = 2'd2;
    localparam logic [1:0] ERR_TX   = 2'd3;

    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWR_UP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rx_seen;
    logic             rx_seen_nxt;
    logic [1:0]       err_code_nxt;
    logic             timed_out;
    logic             tx_drained;

    assign timed_out  = (cnt == TIMEOUT_LAST);
    assign tx_drained = TX_FIFO_EMPTY && !TX_BUSY;

    // Completion inputs are checked before the watchdog so a same-cycle
    // completion always beats a timeout.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt    = state;
        err_code_nxt = ERR_CODE;
        case (state)
            S_PWRUP: begin
                if (cnt == PWRUP_LAST) state_nxt = S_INIT_CR;
            end
            S_INIT_CR: begin
                state_nxt = S_WAIT_CR;
            end
            S_WAIT_CR: begin
                if (DONE_CR) begin
                    state_nxt = S_WAIT_RX;
                end else if (timed_out) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = ERR_CR;
                end
            end
            S_WAIT_RX: begin
                if (rx_seen || SER_RECV_DONE) state_nxt = S_START_LZW;
            end
            S_START_LZW: begin
                state_nxt = S_WAIT_LZW;
            end
            S_WAIT_LZW: begin
                if (LZW_DONE) begin
                    state_nxt = S_DRAIN_TX;
                end else if (timed_out) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = ERR_LZW;
                end
            end
            S_DRAIN_TX: begin
                if (tx_drained) begin
                    state_nxt = S_DONE;
                end else if (timed_out) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = ERR_TX;
                end
            end
            S_DONE: begin
                if (RESTART) state_nxt = S_INIT_CR;
            end
            S_ERROR: begin
                if (RESTART) begin
                    state_nxt    = S_INIT_CR;
                    err_code_nxt = ERR_NONE;
                end
            end
            default: begin
                state_nxt    = S_PWRUP;
                err_code_nxt = ERR_NONE;
            end
        endcase
    end

    // A receive finishing while the RAM is still initialising must not be lost.
    always_comb begin
        rx_seen_nxt = rx_seen;
        if (SER_RECV_DONE && (state inside {S_INIT_CR, S_WAIT_CR, S_WAIT_RX}))
            rx_seen_nxt = 1'b1;
        if (state_nxt == S_START_LZW)
            rx_seen_nxt = 1'b0;
    end

    always_ff @(posedge CLK66 or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_PWRUP;
            cnt        <= '0;
            rx_seen    <= 1'b0;
            PWR_UP     <= 1'b0;
            INIT_CR    <= 1'b0;
            INIT_LZW   <= 1'b0;
            FINAL_DONE <= 1'b0;
            ERR        <= 1'b0;
            ERR_CODE   <= ERR_NONE;
            STATE_DBG  <= S_PWRUP;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            rx_seen <= rx_seen_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            // Outputs are derived from the next state so they change on the
            // same edge as the state register.
            PWR_UP     <= PWR_UP || (state_nxt != S_PWRUP);
            INIT_CR    <= (state_nxt == S_INIT_CR);
            INIT_LZW   <= (state_nxt == S_START_LZW);
            FINAL_DONE <= (state_nxt == S_DONE);
            ERR        <= (state_nxt == S_ERROR);
            ERR_CODE   <= err_code_nxt;
            STATE_DBG  <= state_nxt;
        end
    end

endmodule

// File: tb/tb_lzw_seq_ctrl.sv
// Self-checking bench for lzw_seq_ctrl: directed and randomized flows checked
// against a phase-timing model derived from the sequencing rules.
module tb_lzw_seq_ctrl;

    localparam int PWR = 16;
    localparam int TO  = 100;

    logic       CLK66 = 1'b0;
    logic       RST_N;
    logic       SER_RECV_DONE;
    logic       DONE_CR;
    logic       LZW_DONE;
    logic       TX_BUSY;
    logic       TX_FIFO_EMPTY;
    logic       RESTART;
    logic       PWR_UP;
    logic       INIT_CR;
    logic       INIT_LZW;
    logic       FINAL_DONE;
    logic       ERR;
    logic [1:0] ERR_CODE;
    logic [3:0] STATE_DBG;

    always #5 CLK66 = ~CLK66;

    lzw_seq_ctrl #(
        .PWR_UP_CYCLES (PWR),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (21)
    ) dut (
        .CLK66        (CLK66),
        .RST_N        (RST_N),
        .SER_RECV_DONE(SER_RECV_DONE),
        .DONE_CR      (DONE_CR),
        .LZW_DONE     (LZW_DONE),
        .TX_BUSY      (TX_BUSY),
        .TX_FIFO_EMPTY(TX_FIFO_EMPTY),
        .RESTART      (RESTART),
        .PWR_UP       (PWR_UP),
        .INIT_CR      (INIT_CR),
        .INIT_LZW     (INIT_LZW),
        .FINAL_DONE   (FINAL_DONE),
        .ERR          (ERR),
        .ERR_CODE     (ERR_CODE),
        .STATE_DBG    (STATE_DBG)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic pwr_exp;     // power-up delay has elapsed since the last reset
    logic rx_pending;  // a receive was reported since the last LZW launch

    task automatic step();
        @(posedge CLK66);
        #1;
    endtask

    function automatic logic junk();
        return ($urandom_range(7, 0) == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every output level follows from the phase the sequencer should be in.
    task automatic expect_all(input string tag, input int st, input int code);
        check({tag, ".state"},      STATE_DBG,  st);
        check({tag, ".pwr_up"},     PWR_UP,     pwr_exp);
        check({tag, ".init_cr"},    INIT_CR,    st == 1);
        check({tag, ".init_lzw"},   INIT_LZW,   st == 4);
        check({tag, ".final_done"}, FINAL_DONE, st == 7);
        check({tag, ".err"},        ERR,        st == 8);
        check({tag, ".err_code"},   ERR_CODE,   code);
    endtask

    task automatic quiet_inputs();
        SER_RECV_DONE = 1'b0;
        DONE_CR       = 1'b0;
        LZW_DONE      = 1'b0;
        RESTART       = 1'b0;
        TX_BUSY       = 1'b0;
        TX_FIFO_EMPTY = 1'b1;
    endtask

    // Called just after reset release; ends with INIT_CR observed.
    task automatic power_up_seq(input string name);
        for (int i = 0; i < PWR - 1; i++) begin
            DONE_CR       = junk();
            LZW_DONE      = junk();
            SER_RECV_DONE = junk();
            RESTART       = junk();
            step();
            expect_all({name, ".pwrup_hold"}, 0, 0);
        end
        quiet_inputs();
        step();
        pwr_exp = 1'b1;
        expect_all({name, ".pwrup_done"}, 1, 0);
    endtask

    // Terminal state held against stray pulses, then RESTART back to INIT_CR.
    task automatic hold_and_restart(input string name, input int st, input int code);
        int n;
        n = $urandom_range(4, 1);
        for (int i = 0; i < n; i++) begin
            DONE_CR       = junk();
            LZW_DONE      = junk();
            SER_RECV_DONE = junk();
            TX_BUSY       = junk();
            RESTART       = 1'b0;
            step();
            expect_all({name, ".hold"}, st, code);
        end
        RESTART = 1'b1;
        step();
        quiet_inputs();
        expect_all({name, ".restart"}, 1, 0);
    endtask

    // One pass through the sequence, entered with INIT_CR observed.
    // Delays are the counter value of the cycle carrying the pulse; a delay
    // of TO or more means the pulse never comes. early_at: 0 = receive during
    // INIT_CR, k = receive in WAIT_CR cycle k-1, -1 = none. busy_len: cycles
    // the transmitter stays blocked in DRAIN_TX. abort_at: WAIT_LZW cycle
    // at which an asynchronous reset is applied, -1 = none.
    task automatic run_flow(input string name, input int d_cr, input int early_at,
                            input int d_rx, input int d_lzw, input int busy_len,
                            input int abort_at);
        int  cr_last, lzw_last, tx_last, n_rx, r;
        logic pend_at_rx;

        expect_all({name, ".init"}, 1, 0);
        SER_RECV_DONE = (early_at == 0);
        DONE_CR       = junk();
        LZW_DONE      = junk();
        RESTART       = junk();
        step();
        quiet_inputs();
        expect_all({name, ".wait_cr"}, 2, 0);

        cr_last = (d_cr < TO) ? d_cr : TO - 1;
        for (int i = 0; i <= cr_last; i++) begin
            DONE_CR       = (i == d_cr);
            SER_RECV_DONE = (early_at - 1 == i);
            LZW_DONE      = junk();
            RESTART       = junk();
            step();
            if (i < cr_last) check({name, ".hold_cr"}, STATE_DBG, 2);
        end
        quiet_inputs();
        if (early_at == 0 || (early_at >= 1 && early_at - 1 <= cr_last))
            rx_pending = 1'b1;
        if (d_cr >= TO) begin
            expect_all({name, ".cr_timeout"}, 8, 1);
            hold_and_restart({name, ".err_cr"}, 8, 1);
            return;
        end
        expect_all({name, ".wait_rx"}, 3, 0);

        pend_at_rx = rx_pending;
        n_rx = pend_at_rx ? 0 : d_rx;
        for (int i = 0; i <= n_rx; i++) begin
            SER_RECV_DONE = !pend_at_rx && (i == d_rx);
            DONE_CR       = junk();
            LZW_DONE      = junk();
            RESTART       = junk();
            step();
            if (i < n_rx) check({name, ".hold_rx"}, STATE_DBG, 3);
        end
        quiet_inputs();
        rx_pending = 1'b0;
        expect_all({name, ".start_lzw"}, 4, 0);

        DONE_CR  = junk();
        LZW_DONE = junk();
        step();
        quiet_inputs();
        expect_all({name, ".wait_lzw"}, 5, 0);

        lzw_last = (d_lzw < TO) ? d_lzw : TO - 1;
        for (int i = 0; i <= lzw_last; i++) begin
            if (i == abort_at) begin
                #2;
                RST_N = 1'b0;
                #1;
                pwr_exp    = 1'b0;
                rx_pending = 1'b0;
                expect_all({name, ".async_rst"}, 0, 0);
                quiet_inputs();
                step();
                step();
                expect_all({name, ".in_rst"}, 0, 0);
                RST_N = 1'b1;
                power_up_seq({name, ".rerun"});
                return;
            end
            LZW_DONE      = (i == d_lzw);
            DONE_CR       = junk();
            SER_RECV_DONE = junk();
            RESTART       = junk();
            TX_BUSY       = junk();
            TX_FIFO_EMPTY = !junk();
            step();
            if (i < lzw_last) check({name, ".hold_lzw"}, STATE_DBG, 5);
        end
        quiet_inputs();
        if (d_lzw >= TO) begin
            expect_all({name, ".lzw_timeout"}, 8, 2);
            hold_and_restart({name, ".err_lzw"}, 8, 2);
            return;
        end
        expect_all({name, ".drain"}, 6, 0);

        tx_last = (busy_len < TO) ? busy_len : TO - 1;
        for (int i = 0; i <= tx_last; i++) begin
            if (i < busy_len) begin
                r = $urandom_range(2, 0);
                TX_BUSY       = (r != 1);
                TX_FIFO_EMPTY = (r == 2);
            end else begin
                TX_BUSY       = 1'b0;
                TX_FIFO_EMPTY = 1'b1;
            end
            DONE_CR       = junk();
            LZW_DONE      = junk();
            SER_RECV_DONE = junk();
            RESTART       = junk();
            step();
            if (i < tx_last) begin
                check({name, ".hold_tx"}, STATE_DBG, 6);
                check({name, ".no_done"}, FINAL_DONE, 0);
            end
        end
        quiet_inputs();
        if (busy_len >= TO) begin
            expect_all({name, ".tx_timeout"}, 8, 3);
            hold_and_restart({name, ".err_tx"}, 8, 3);
            return;
        end
        expect_all({name, ".done"}, 7, 0);
        hold_and_restart({name, ".fin"}, 7, 0);
    endtask

    function automatic int pick(input int lo_max);
        if ($urandom_range(3, 0) == 0) return int'($urandom_range(TO + 3, TO - 3));
        return int'($urandom_range(lo_max, 0));
    endfunction

    initial begin
        RST_N      = 1'b0;
        quiet_inputs();
        pwr_exp    = 1'b0;
        rx_pending = 1'b0;
        #3;
        expect_all("reset", 0, 0);
        step();
        step();
        RST_N = 1'b1;
        power_up_seq("por");

        run_flow("nominal",       5,      -1, 19, 29,     0,      -1);
        run_flow("early_rx",      7,       3, 50, 10,     0,      -1);
        run_flow("cr_watchdog",   TO + 5, -1,  0,  0,     0,      -1);
        run_flow("cr_race",       TO - 1, -1,  2,  5,     0,      -1);
        run_flow("rx_in_init",    4,       0, 30,  3,     0,      -1);
        run_flow("lzw_race",      3,      -1,  4, TO - 1, 0,      -1);
        run_flow("lzw_watchdog",  3,      -1,  4, TO + 1, 0,      -1);
        run_flow("drain_busy",    2,      -1,  1,  6,     40,     -1);
        run_flow("drain_race",    2,      -1,  1,  6,     TO - 1, -1);
        run_flow("tx_watchdog",   2,      -1,  1,  6,     TO + 3, -1);
        run_flow("early_then_to", TO + 2, 20,  0,  0,     0,      -1);
        run_flow("pending_rx",    4,      -1, 30,  5,     0,      -1);

        for (int k = 0; k < 10; k++) begin
            int rc, re, rr, rl, rb;
            rc = pick(20);
            re = ($urandom_range(2, 0) == 0) ? int'($urandom_range(30, 0)) : -1;
            rr = int'($urandom_range(25, 0));
            rl = pick(40);
            rb = pick(50);
            run_flow("random", rc, re, rr, rl, rb, -1);
        end

        run_flow("async_rst",   3, -1, 2, 50, 0, 20);
        run_flow("after_reset", 1, -1, 3,  2, 5, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
